// File: rtl/prog_loader.sv
// prog_loader: receives a framed program over a slow pin-level strobe
// handshake and writes it into the core's instruction/data memory.
// Frame: LEN byte N, N data bytes, CHK byte (XOR of the data bytes).
// The core is held (cpu_run=0) until a frame's checksum verifies.
module prog_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              byte_stb,
  input  logic [DATA_W-1:0] byte_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  // Synchronizer chains: [0],[1] synchronize, [2] is the edge-detect history.
  logic [2:0]        ld_sync_q,  ld_sync_d;
  logic [2:0]        stb_sync_q, stb_sync_d;
  // Registered edge pulses and the byte captured alongside acc.
  logic              ld_rise_q,  ld_rise_d;
  logic              acc_q,      acc_d;
  logic [DATA_W-1:0] byte_q,     byte_d;
  // Frame bookkeeping.
  state_t            state_q,    state_d;
  logic [ADDR_W:0]   len_q,      len_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] chk_q,      chk_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
  // Registered outputs.
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q,   cpu_run_d;
  logic              busy_q,      busy_d;
  logic              err_q,       err_d;

  // Synchronize pins, detect rising edges, capture the strobed byte.
  always_comb begin
    ld_sync_d  = {ld_sync_q[1:0], load_en};
    stb_sync_d = {stb_sync_q[1:0], byte_stb};
    ld_rise_d  = ld_sync_q[1] & ~ld_sync_q[2];
    acc_d      = stb_sync_q[1] & ~stb_sync_q[2];
    byte_d     = acc_d ? byte_in : byte_q;
  end

  // Frame state machine; ld_rise takes priority over a coincident acc,
  // discarding that byte. Outputs are derived from the next state so they
  // are registered together with it.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    chk_d       = chk_q;
    byte_cnt_d  = byte_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (ld_rise_q) begin
      state_d    = S_LEN;
      byte_cnt_d = '0;
    end else if (acc_q) begin
      unique case (state_q)
        S_LEN: begin
          if (byte_q == '0 || byte_q > DATA_W'(MEM_DEPTH)) begin
            state_d = S_ERR;
          end else begin
            len_d      = (ADDR_W+1)'(byte_q);
            addr_d     = '0;
            chk_d      = '0;
            byte_cnt_d = '0;
            state_d    = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = byte_q;
          chk_d       = chk_q ^ byte_q;
          addr_d      = addr_q + ADDR_W'(1);
          byte_cnt_d  = byte_cnt_q + (ADDR_W+1)'(1);
          if (byte_cnt_q + (ADDR_W+1)'(1) == len_q) begin
            state_d = S_CHK;
          end
        end
        S_CHK: begin
          state_d = (byte_q == chk_q) ? S_RUN : S_ERR;
        end
        default: begin
          // IDLE, RUN and ERR ignore further bytes
        end
      endcase
    end

    cpu_run_d = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
    busy_d    = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
  end

  // All state and outputs; async reset returns to IDLE and kills any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_sync_q   <= '0;
      stb_sync_q  <= '0;
      ld_rise_q   <= 1'b0;
      acc_q       <= 1'b0;
      byte_q      <= '0;
      state_q     <= S_IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      chk_q       <= '0;
      byte_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ld_sync_q   <= ld_sync_d;
      stb_sync_q  <= stb_sync_d;
      ld_rise_q   <= ld_rise_d;
      acc_q       <= acc_d;
      byte_q      <= byte_d;
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      chk_q       <= chk_d;
      byte_cnt_q  <= byte_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames, hand-written corner sequences,
// and random frames checked against a frame-level reference model.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic       byte_stb;
  logic [7:0] byte_in;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       err;
  logic [5:0] byte_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  prog_loader #(.ADDR_W(5), .DATA_W(8), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .byte_stb(byte_stb),
    .byte_in(byte_in), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Observed writes {addr, data}
  logic [12:0] wr_q[$];
  always @(negedge clk) if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});

  // Expected results from the model
  logic [12:0] exp_wq[$];
  bit          m_err, m_run;
  int          m_cnt;
  logic [7:0]  fr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: what a single frame (after a load request) must produce.
  function automatic void model(input logic [7:0] f[$]);
    int n;
    logic [7:0] x;
    exp_wq.delete();
    m_err = 0; m_run = 0; m_cnt = 0;
    if (f.size() == 0) return;
    n = f[0];
    if (n == 0 || n > 32) begin m_err = 1; return; end
    x = 8'h00;
    for (int i = 1; i <= n && i < f.size(); i++) begin
      exp_wq.push_back({5'(i-1), f[i]});
      x ^= f[i];
      m_cnt++;
    end
    if (f.size() > n + 1) begin
      if (f[n+1] == x) m_run = 1; else m_err = 1;
    end
  endfunction

  task automatic compare(input string name, input bit e_err, input bit e_run, input int e_cnt);
    check({name, ".nwr"}, wr_q.size(), exp_wq.size());
    for (int i = 0; i < exp_wq.size() && i < wr_q.size(); i++)
      check({name, ".wr"}, wr_q[i], exp_wq[i]);
    check({name, ".err"}, err, e_err);
    check({name, ".run"}, cpu_run, e_run);
    check({name, ".cnt"}, byte_cnt, e_cnt);
  endtask

  task automatic pulse_load();
    @(negedge clk); load_en = 1'b1;
    repeat (5) @(negedge clk);
    load_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold,
                           output int lat_we, output int lat_run);
    bit run0;
    @(negedge clk);
    byte_in = b; byte_stb = 1'b1;
    run0 = cpu_run; lat_we = -1; lat_run = -1;
    for (int k = 1; k <= hold + 10; k++) begin
      @(negedge clk);
      if (k == hold) byte_stb = 1'b0;
      if (mem_we && lat_we < 0) lat_we = k;
      if (cpu_run && !run0 && lat_run < 0) lat_run = k;
    end
    byte_stb = 1'b0;
  endtask

  task automatic send_frame(input int hold);
    int lw, lr;
    wr_q.delete();
    pulse_load();
    foreach (fr[i]) send_byte(fr[i], hold, lw, lr);
  endtask

  typedef struct {
    int len; int ndata; bit good;
    bit e_err; bit e_run; int e_cnt; int e_nw;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lw, lr, k;
    logic [7:0] x, a, b, c, d;

    rst = 1'b1; load_en = 1'b0; byte_stb = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.mem_we", mem_we, 0);
    check("rst.run", cpu_run, 0);
    check("rst.busy", busy, 0);
    check("rst.err", err, 0);
    check("rst.cnt", byte_cnt, 0);
    check("rst.addr", mem_addr, 0);
    check("rst.wdata", mem_wdata, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal load with latency checks
    wr_q.delete();
    pulse_load();
    check("nom.busy", busy, 1);
    check("nom.run0", cpu_run, 0);
    send_byte(8'h03, 1, lw, lr);
    send_byte(8'h11, 1, lw, lr);
    check("nom.lat_we", lw, 4);
    send_byte(8'h22, 1, lw, lr);
    send_byte(8'h43, 1, lw, lr);
    send_byte(8'h70, 1, lw, lr);
    check("nom.lat_run", lr, 4);
    fr = '{8'h03, 8'h11, 8'h22, 8'h43, 8'h70};
    model(fr);
    compare("nom", 0, 1, 3);

    // Bad checksum, then reload clears err
    fr = '{8'h03, 8'h11, 8'h22, 8'h43, 8'h71};
    send_frame(1);
    model(fr);
    compare("badchk", 1, 0, 3);
    pulse_load();
    check("reload.err", err, 0);
    check("reload.busy", busy, 1);
    check("reload.cnt", byte_cnt, 0);

    // Table of frames
    tbl[0] = '{0,   0,  1, 1, 0, 0,  0};
    tbl[1] = '{33,  0,  1, 1, 0, 0,  0};
    tbl[2] = '{32,  32, 1, 0, 1, 32, 32};
    tbl[3] = '{1,   1,  1, 0, 1, 1,  1};
    tbl[4] = '{5,   5,  0, 1, 0, 5,  5};
    tbl[5] = '{255, 0,  1, 1, 0, 0,  0};
    tbl[6] = '{4,   4,  1, 0, 1, 4,  4};
    foreach (tbl[t]) begin
      fr.delete();
      fr.push_back(8'(tbl[t].len));
      x = 8'h00;
      for (int i = 0; i < tbl[t].ndata; i++) begin
        fr.push_back(8'(i * 37 + tbl[t].len));
        x ^= 8'(i * 37 + tbl[t].len);
      end
      if (tbl[t].ndata > 0) fr.push_back(tbl[t].good ? x : (x ^ 8'h01));
      send_frame(1);
      check("tbl.nwr", wr_q.size(), tbl[t].e_nw);
      for (int i = 0; i < wr_q.size(); i++)
        check("tbl.wr", wr_q[i], {5'(i), 8'(i * 37 + tbl[t].len)});
      check("tbl.err", err, tbl[t].e_err);
      check("tbl.run", cpu_run, tbl[t].e_run);
      check("tbl.cnt", byte_cnt, tbl[t].e_cnt);
      check("tbl.busy", busy, 0);
    end

    // Strobe held high for 20 clk counts once
    fr = '{8'h01, 8'h33, 8'h33};
    send_frame(20);
    model(fr);
    compare("hold", 0, 1, 1);

    // Two strobes with a single-sample high and a 1-clk gap: both accepted
    wr_q.delete();
    pulse_load();
    send_byte(8'h02, 1, lw, lr);
    @(negedge clk); byte_in = 8'h5A; byte_stb = 1'b1;
    @(negedge clk); byte_stb = 1'b0;
    @(negedge clk); byte_stb = 1'b1;
    @(negedge clk); byte_stb = 1'b0;
    repeat (10) @(negedge clk);
    send_byte(8'h00, 1, lw, lr);
    fr = '{8'h02, 8'h5A, 8'h5A, 8'h00};
    model(fr);
    compare("fast", 0, 1, 2);

    // Restart mid-frame after 2 of 3 data bytes
    a = 8'hA1; b = 8'hB2; c = 8'hC3; d = 8'hD4;
    wr_q.delete();
    pulse_load();
    send_byte(8'h03, 1, lw, lr);
    send_byte(a, 1, lw, lr);
    send_byte(b, 1, lw, lr);
    pulse_load();
    check("restart.cnt0", byte_cnt, 0);
    send_byte(8'h02, 1, lw, lr);
    send_byte(c, 1, lw, lr);
    send_byte(d, 1, lw, lr);
    send_byte(c ^ d, 1, lw, lr);
    exp_wq = '{{5'd0, a}, {5'd1, b}, {5'd0, c}, {5'd1, d}};
    compare("restart", 0, 1, 2);

    // Restart while running: cpu_run drops, back to LEN
    @(negedge clk); load_en = 1'b1;
    k = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!cpu_run && k < 0) begin
        k = i;
        check("runrst.busy", busy, 1);
        check("runrst.cnt", byte_cnt, 0);
      end
    end
    check("runrst.dropped", (k > 0), 1);
    load_en = 1'b0;
    repeat (5) @(negedge clk);

    // Async reset between acc and mem_we
    wr_q.delete();
    pulse_load();
    send_byte(8'h03, 1, lw, lr);
    @(negedge clk); byte_in = 8'h77; byte_stb = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; byte_stb = 1'b0;
    #1;
    check("arst.mem_we", mem_we, 0);
    check("arst.busy", busy, 0);
    check("arst.run", cpu_run, 0);
    check("arst.err", err, 0);
    check("arst.cnt", byte_cnt, 0);
    check("arst.addr", mem_addr, 0);
    check("arst.wdata", mem_wdata, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("arst.nwr", wr_q.size(), 0);
    check("arst.idle_busy", busy, 0);
    send_byte(8'h05, 1, lw, lr);
    check("idle.ignore_we", wr_q.size(), 0);
    check("idle.ignore_busy", busy, 0);

    // Random frames against the model
    for (int r = 0; r < 12; r++) begin
      int n;
      int sel;
      sel = $urandom_range(0, 5);
      if (sel == 0) n = 0;
      else if (sel == 1) n = $urandom_range(33, 255);
      else n = $urandom_range(1, 32);
      fr.delete();
      fr.push_back(8'(n));
      x = 8'h00;
      if (n >= 1 && n <= 32) begin
        for (int i = 0; i < n; i++) begin
          fr.push_back(8'($urandom));
          x ^= fr[i+1];
        end
        fr.push_back(($urandom_range(0, 3) != 0) ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
      end
      if ($urandom_range(0, 3) == 0) fr.push_back(8'($urandom));
      send_frame(1);
      model(fr);
      compare("rand", m_err, m_run, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
